// File: rtl/fetch_queue_pkg.sv
// Shared types and sizing for the fetch queue and the decode stage that unpacks it.
package fetch_queue_pkg;

  localparam int unsigned XLEN              = 32;
  localparam int unsigned FETCH_QUEUE_DEPTH = 16;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
    logic [XLEN-1:0] pred_npc;
  } fq_entry_t;

endpackage

// File: rtl/fetch_queue_if.sv
// Enqueue (frontend) and dequeue (backend) handshakes of the fetch queue.
interface fetch_queue_if;
  import fetch_queue_pkg::*;

  logic            enq_valid;
  logic            enq_ready;
  logic [XLEN-1:0] enq_pc;
  logic [XLEN-1:0] enq_inst;
  logic [XLEN-1:0] enq_pred_npc;

  logic            deq_valid;
  logic            deq_ready;
  logic [XLEN-1:0] deq_pc;
  logic [XLEN-1:0] deq_inst;
  logic [XLEN-1:0] deq_pred_npc;

  // Frontend producer plus backend consumer
  modport master (
    output enq_valid, enq_pc, enq_inst, enq_pred_npc, deq_ready,
    input  enq_ready, deq_valid, deq_pc, deq_inst, deq_pred_npc
  );

  // The queue itself
  modport slave (
    input  enq_valid, enq_pc, enq_inst, enq_pred_npc, deq_ready,
    output enq_ready, deq_valid, deq_pc, deq_inst, deq_pred_npc
  );
endinterface

// File: rtl/fetch_queue.sv
// Circular instruction buffer decoupling fetch from decode; flush empties it in one edge.
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter  int unsigned DEPTH = FETCH_QUEUE_DEPTH,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  fetch_queue_if.slave     fq,
  input  logic             flush,
  output logic [CNT_W-1:0] count
);

  fq_entry_t        mem [DEPTH];
  fq_entry_t        enq_entry;
  fq_entry_t        head;
  logic [CNT_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] rd_ptr_q, rd_ptr_d;
  logic             full, empty, enq_fire, deq_fire;

  // MSB is the wrap bit: equal indices with differing wrap bits means full
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]) &&
                 (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]);

  assign fq.enq_ready = !full;
  assign fq.deq_valid = !empty;
  assign count        = wr_ptr_q - rd_ptr_q;

  assign enq_fire = fq.enq_valid && !full  && !flush;
  assign deq_fire = fq.deq_ready && !empty && !flush;

  assign enq_entry = '{pc: fq.enq_pc, inst: fq.enq_inst, pred_npc: fq.enq_pred_npc};

  // Storage carries no reset; validity comes solely from the pointers
  always_ff @(posedge clk) begin
    if (enq_fire) begin
      mem[wr_ptr_q[PTR_W-1:0]] <= enq_entry;
    end
  end

  assign head            = mem[rd_ptr_q[PTR_W-1:0]];
  assign fq.deq_pc       = head.pc;
  assign fq.deq_inst     = head.inst;
  assign fq.deq_pred_npc = head.pred_npc;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (enq_fire) wr_ptr_d = wr_ptr_q + CNT_W'(1);
      if (deq_fire) rd_ptr_d = rd_ptr_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Randomized scoreboard bench for fetch_queue against an in-order queue reference.
module tb_fetch_queue;
  import fetch_queue_pkg::*;

  localparam int unsigned DEPTH = FETCH_QUEUE_DEPTH;
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             flush = 1'b0;
  logic [CNT_W-1:0] count;

  fetch_queue_if fq_if ();

  fetch_queue #(.DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst   (rst),
    .fq    (fq_if),
    .flush (flush),
    .count (count)
  );

  always #5 clk = ~clk;

  fq_entry_t sb[$];
  int        errors = 0;
  int        checks = 0;
  bit        enq_ok = 1'b1;
  bit        mon_en = 1'b1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compares presented outputs with the reference and retires consumed entries
  always @(negedge clk) begin
    if (rst && mon_en) begin
      chk("count",     32'(count),           32'(sb.size()));
      chk("enq_ready", 32'(fq_if.enq_ready), 32'(sb.size() < DEPTH));
      chk("deq_valid", 32'(fq_if.deq_valid), 32'(sb.size() != 0));
      enq_ok = (sb.size() < DEPTH);
      if (sb.size() != 0) begin
        chk("deq_pc",       fq_if.deq_pc,       sb[0].pc);
        chk("deq_inst",     fq_if.deq_inst,     sb[0].inst);
        chk("deq_pred_npc", fq_if.deq_pred_npc, sb[0].pred_npc);
        if (fq_if.deq_ready && !flush) void'(sb.pop_front());
      end
    end
  end

  // Reference: accepted offers join the tail; flush empties everything
  always @(posedge clk) begin
    if (rst) begin
      if (flush) sb.delete();
      else if (fq_if.enq_valid && enq_ok)
        sb.push_back('{pc: fq_if.enq_pc, inst: fq_if.enq_inst, pred_npc: fq_if.enq_pred_npc});
    end
  end

  task automatic cyc(input bit ev, input bit dr, input bit fl, input logic [31:0] pc);
    fq_if.enq_valid    = ev;
    fq_if.enq_pc       = pc;
    fq_if.enq_inst     = $urandom;
    fq_if.enq_pred_npc = pc + 32'd4;
    fq_if.deq_ready    = dr;
    flush              = fl;
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs();
    chk("rst_deq_valid", 32'(fq_if.deq_valid), 32'd0);
    chk("rst_enq_ready", 32'(fq_if.enq_ready), 32'd1);
    chk("rst_count",     32'(count),           32'd0);
  endtask

  task automatic mid_reset();
    fq_if.enq_valid = 1'b0;
    fq_if.deq_ready = 1'b0;
    flush           = 1'b0;
    #2 rst = 1'b0;
    #1;
    check_reset_outputs();
    sb.delete();
    rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] pc;
    int          ep, dp;
    fq_if.enq_valid    = 1'b0;
    fq_if.enq_pc       = '0;
    fq_if.enq_inst     = '0;
    fq_if.enq_pred_npc = '0;
    fq_if.deq_ready    = 1'b0;

    // Asynchronous reset asserted between clock edges
    #2 rst = 1'b0;
    #1;
    check_reset_outputs();
    #5 rst = 1'b1;
    @(posedge clk);
    #1;

    // Fill to full, then one refused offer
    for (int i = 0; i < 16; i++) cyc(1'b1, 1'b0, 1'b0, 32'h1000 + 32'(4 * i));
    chk("full_count", 32'(count), 32'd16);
    chk("full_head",  fq_if.deq_pc, 32'h1000);
    cyc(1'b1, 1'b0, 1'b0, 32'hDEAD_0000);

    // Full with simultaneous dequeue: enqueue refused, accepted the cycle after
    cyc(1'b1, 1'b1, 1'b0, 32'h1040);
    chk("full_deq_count", 32'(count), 32'd15);
    cyc(1'b1, 1'b0, 1'b0, 32'h1040);
    chk("refill_count", 32'(count), 32'd16);

    // Drain in order, then empty
    for (int i = 0; i < 17; i++) cyc(1'b0, 1'b1, 1'b0, 32'h0);
    chk("drained_valid", 32'(fq_if.deq_valid), 32'd0);

    // Streaming across the wrap point
    for (int i = 0; i < 40; i++) cyc(1'b1, 1'b1, 1'b0, 32'h4000 + 32'(4 * i));
    chk("stream_count", 32'(count), 32'd1);
    cyc(1'b0, 1'b1, 1'b0, 32'h0);

    // Flush with a simultaneous enqueue
    for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, 1'b0, 32'h5000 + 32'(4 * i));
    cyc(1'b1, 1'b1, 1'b1, 32'h2000);
    chk("flush_count", 32'(count), 32'd0);
    chk("flush_valid", 32'(fq_if.deq_valid), 32'd0);
    cyc(1'b1, 1'b0, 1'b0, 32'h3000);
    chk("post_flush_head", fq_if.deq_pc, 32'h3000);
    cyc(1'b0, 1'b1, 1'b0, 32'h0);

    // Random traffic with varying producer/consumer bias
    pc = 32'h8000;
    for (int seg = 0; seg < 4; seg++) begin
      ep = (seg % 2 == 0) ? 85 : 35;
      dp = (seg % 2 == 0) ? 30 : 85;
      for (int i = 0; i < 120; i++) begin
        cyc(32'($urandom_range(0, 99)) < 32'(ep), 32'($urandom_range(0, 99)) < 32'(dp),
            $urandom_range(0, 99) < 3, pc);
        pc += 32'd4;
      end
    end

    // Reset mid-operation, then immediate re-use
    for (int i = 0; i < 6; i++) cyc(1'b1, 1'b0, 1'b0, 32'h9000 + 32'(4 * i));
    mid_reset();
    cyc(1'b1, 1'b0, 1'b0, 32'hA000);
    chk("post_reset_count", 32'(count), 32'd1);
    chk("post_reset_head",  fq_if.deq_pc, 32'hA000);
    for (int i = 0; i < 60; i++) begin
      cyc($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, 1'b0, pc);
      pc += 32'd4;
    end
    for (int i = 0; i < 20; i++) cyc(1'b0, 1'b1, 1'b0, 32'h0);
    chk("final_empty", 32'(fq_if.deq_valid), 32'd0);

    mon_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
